digit_serial_addsub: RTL and testbench

//  Parametrised adder/subtractor, WIDTH bits wide. Processes DIGIT bits per clock, LSB digit first.

---
 rtl/digit_serial_addsub.sv | 136 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
// Valid/ready handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Producers hold valid (and data) until that edge. in_ready is high only in IDLE;
// out_valid is high only in DONE, and the result is held stable until its transfer edge.
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_addsub: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_dig;
    logic             w_msb_cin;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(NDIG - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status outputs, all decoded from the current state
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One digit of ripple addition; operands are shifted so the live digit is always at bit 0.
    // The carry into the top result bit is recovered as a^b^s of that bit, which on the last
    // digit is the carry into the word MSB needed for signed overflow.
    always_comb begin
        w_dig      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
        w_msb_cin  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dig[DIGIT-1];
        w_sum_next = r_sum;
        w_sum_next[r_cnt*DIGIT +: DIGIT] = w_dig[DIGIT-1:0];
    end

    // Operand capture at accept (b and carry pre-inverted for subtract), digit step in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~c_in : c_in;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dig[DIGIT];
            r_sum   <= w_sum_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_dig[DIGIT];
                r_ovf  <= w_msb_cin ^ w_dig[DIGIT];
                r_zero <= (w_sum_next == '0);
            end
        end
    end

    assign sum      = r_sum;
    assign c_out    = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT = 2, 8, 1) share one stimulus stream.
// Expected results come from plain integer arithmetic and are queued per instance at issue;
// a monitor pops and compares whenever an instance hands over a result.
module tb_digit_serial_addsub;
  localparam int W  = 8;
  localparam int NI = 3;

  function automatic int dig_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 8 : 1);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c_in;
  logic          sub;
  logic          out_ready;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] c_out;
  logic [NI-1:0] overflow;
  logic [NI-1:0] zero;
  logic [NI-1:0] busy;
  logic [W-1:0]  sum_o [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    digit_serial_addsub #(.WIDTH(W), .DIGIT(dig_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .sum       (sum_o[g]),
      .c_out     (c_out[g]),
      .overflow  (overflow[g]),
      .zero      (zero[g]),
      .busy      (busy[g])
    );
  end

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q [NI][$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: {zero, overflow, c_out, sum} from integer arithmetic on the operand values
  function automatic logic [W+2:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input logic s);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int ci = c;
    int r;
    int sr;
    logic co;
    logic ov;
    logic [W-1:0] res;
    if (!s) begin
      r  = ux + uy + ci;
      sr = sx + sy + ci;
      co = (r > 255);
    end else begin
      r  = ux - uy - ci;
      sr = sx - sy - ci;
      co = (r >= 0);
    end
    res = r[W-1:0];
    ov  = (sr > 127) || (sr < -128);
    return {(res == 0), ov, co, res};
  endfunction

  // Monitor: a result transfers on the next rising edge when out_valid && out_ready
  initial begin
    logic [W+2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_ready === 1'b1) begin
        for (int g = 0; g < NI; g++) begin
          if (out_valid[g]) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("unexpected_result_d%0d", dig_of(g)), 16'(out_valid[g]), 16'h0);
            end else begin
              e = exp_q[g].pop_front();
              check($sformatf("result_d%0d", dig_of(g)),
                    16'({zero[g], overflow[g], c_out[g], sum_o[g]}), 16'(e));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    int n = 0;
    while (in_ready !== '1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("in_ready_wait", 16'(in_ready), 16'(3'b111));
    a = x; b = y; c_in = c; sub = s; in_valid = 1'b1;
    for (int g = 0; g < NI; g++) exp_q[g].push_back(ref_model(x, y, c, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    int left;
    do begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      left = 0;
      for (int g = 0; g < NI; g++) left += exp_q[g].size();
    end while ((busy != '0 || left != 0) && n < 300);
    out_ready = 1'b0;
    check("drain_busy", 16'(busy), 16'h0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    issue(x, y, c, s);
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat [NI];
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_state_d%0d", dig_of(g)),
            16'({in_ready[g], out_valid[g], busy[g], c_out[g], overflow[g], zero[g], sum_o[g]}),
            16'({1'b1, 5'b0, 8'h00}));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency, then a 10-cycle stall in DONE with operand pulses that must be ignored
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    check("busy_after_accept", 16'(busy), 16'(3'b111));
    for (int g = 0; g < NI; g++) lat[g] = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) if (out_valid[g] && lat[g] == 0) lat[g] = k;
    end
    for (int g = 0; g < NI; g++)
      check($sformatf("latency_d%0d", dig_of(g)), 16'(lat[g]), 16'(W / dig_of(g)));
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0); a = W'($urandom); b = W'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check("stall_in_ready", 16'(in_ready), 16'h0);
      for (int g = 0; g < NI; g++)
        check($sformatf("stall_hold_d%0d", dig_of(g)),
              16'({out_valid[g], zero[g], overflow[g], c_out[g], sum_o[g]}), 16'({1'b1, 11'h010}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 16'(in_ready), 16'(3'b111));
    check("release_busy", 16'(busy), 16'h0);

    // Reset while the DIGIT=2 instance is at digit 2 of RUN
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 16'(out_valid), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    for (int g = 0; g < NI; g++) exp_q[g].delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_abort_out_valid", 16'(out_valid), 16'h0);

    // Directed vectors
    do_op(8'h0F, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h00, 1'b1, 1'b0);
    do_op(8'h05, 8'h07, 1'b0, 1'b1);
    do_op(8'h05, 8'h07, 1'b1, 1'b1);
    do_op(8'h00, 8'h00, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 1'b1);

    // Random operations
    for (int i = 0; i < 60; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    for (int g = 0; g < NI; g++)
      check($sformatf("queue_empty_d%0d", dig_of(g)), 16'(exp_q[g].size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop if something wedges beyond every bounded loop
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
